keypad_scan: RTL and testbench

- Scanning driver for the Nexys 3 Pmod KYPD 4x4 hex keypad; it is the input-side counterpart of the seven-segment driver.
- Instead of multiplexing digits out, it strobes keypad columns, samples the rows, debounces whole scan frames and decodes one key to a 4-bit hex code.
- The decoded key is presented through a one-entry valid/ack holding register, so a CPU or a display path can consume keypresses at its own pace.

---
 rtl/keypad_scan_pkg.sv | 76 +++++++
 rtl/keypad_scan_sync2.sv | 26 ++
 rtl/keypad_scan.sv | 174 +++++++++++++++++
 tb/tb_keypad_scan.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 hex keypad scanner.
// Holds the column reset pattern, frame classification codes and keymap.
// Combinational helpers only; no state lives here.
package keypad_scan_pkg;

    // Result of looking at one complete 16-bit scan frame.
    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } frame_cls_e;

    // Debounce candidate: either "no key" or one key position (r*4+c).
    // pos is forced to 0 for "no key" so whole-struct equality is meaningful.
    typedef struct packed {
        logic       single;
        logic [3:0] pos;
    } cand_t;

    typedef struct packed {
        frame_cls_e cls;
        logic [3:0] pos;
    } frame_info_t;

    // Column 0 strobed (active-low) straight out of reset.
    localparam logic [3:0] COL_RST   = 4'b1110;
    localparam cand_t      CAND_NONE = '{single: 1'b0, pos: 4'd0};

    // Key position r*4+c to the hex legend printed on the keypad.
    function automatic logic [3:0] keymap(input logic [3:0] pos);
        logic [3:0] code;
        case (pos)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'h0;
            4'd13:   code = 4'hF;
            4'd14:   code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Counts set bits and reports the position of the (only) set bit when
    // there is exactly one; for MULTI the position is meaningless.
    function automatic frame_info_t classify_frame(input logic [15:0] snap);
        frame_info_t info;
        logic [4:0]  n;
        n        = 5'd0;
        info.pos = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap[i]) begin
                n        = n + 5'd1;
                info.pos = 4'(i);
            end
        end
        if (n == 5'd0) begin
            info.cls = CLS_NONE;
        end else if (n == 5'd1) begin
            info.cls = CLS_SINGLE;
        end else begin
            info.cls = CLS_MULTI;
        end
        return info;
    endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchronizer for a W-bit bus of independent asynchronous levels.
// Latency: 2 clk cycles. No backpressure; samples every cycle.
// Ports: clk, rst_n (sync, active-low), d (async in), q (synchronized out).
module keypad_scan_sync2 #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// Pmod KYPD scanner: strobes columns, debounces whole frames, decodes one hex key.
// Latency: key_valid one cycle after the D-th identical single-key frame ends.
// Backpressure: one-entry valid/ack holder; a press arriving while full sets overrun.
// Ports: clk, rst_n (sync, active-low), row[3:0] (async, active-low),
//        col[3:0] (one-hot-low strobe), key/key_valid/key_ack (press holder),
//        pressed (debounced level), overrun/overrun_clr (sticky drop flag).
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int N = 14,   // column slot is 2**N cycles, N >= 2
    parameter int D = 4     // identical frames to accept a change, 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       pressed,
    output logic       overrun,
    input  logic       overrun_clr
);

    localparam logic [3:0] D_SAT = 4'(D);

    // ------------------------------------------------------------------
    // Row synchronizer: idle rows read as released (all ones).
    // ------------------------------------------------------------------
    logic [3:0] row_s;

    keypad_scan_sync2 #(
        .W       (4),
        .RST_VAL (4'hF)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row),
        .q     (row_s)
    );

    // ------------------------------------------------------------------
    // Column scan. Rows are sampled on the last cycle of each slot, which
    // leaves 2**N-1 cycles for the keypad lines and synchronizer to settle.
    // ------------------------------------------------------------------
    logic [N-1:0] slot_cnt;
    logic [1:0]   col_idx;
    logic [3:0]   col_q;
    logic [15:0]  snap;
    logic [15:0]  snap_nxt;
    logic         frame_done;
    logic         slot_end;

    assign slot_end = &slot_cnt;
    assign col      = col_q;

    // Only the four bits belonging to the current column are rewritten, so
    // the snapshot is complete and fresh once column 3 has been sampled.
    always_comb begin
        snap_nxt = snap;
        if (slot_end) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (2'(c) == col_idx) begin
                        snap_nxt[r*4+c] = ~row_s[r];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt   <= '0;
            col_idx    <= 2'd0;
            col_q      <= COL_RST;
            snap       <= 16'h0000;
            frame_done <= 1'b0;
        end else begin
            slot_cnt   <= slot_cnt + 1'b1;
            snap       <= snap_nxt;
            frame_done <= slot_end && (col_idx == 2'd3);
            if (slot_end) begin
                col_idx <= col_idx + 2'd1;
                col_q   <= {col_q[2:0], col_q[3]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame debounce. MULTI frames are invisible to the stability logic so
    // a brief second finger neither resets nor advances the count.
    // ------------------------------------------------------------------
    frame_info_t fi;
    cand_t       cand;
    cand_t       last_cand;
    cand_t       deb;
    logic [3:0]  stab;
    logic [3:0]  stab_nxt;
    logic        same;
    logic        upd;
    logic        commit;
    logic        press_ev;
    logic        drop;

    always_comb begin
        fi          = classify_frame(snap);
        cand        = CAND_NONE;
        if (fi.cls == CLS_SINGLE) begin
            cand.single = 1'b1;
            cand.pos    = fi.pos;
        end
        same     = (cand == last_cand);
        stab_nxt = 4'd1;
        if (same) begin
            stab_nxt = (stab >= D_SAT) ? D_SAT : stab + 4'd1;
        end
        upd      = frame_done && (fi.cls != CLS_MULTI);
        commit   = upd && (stab_nxt == D_SAT) && (cand != deb);
        // Only a NONE -> SINGLE transition is a keypress; sliding from one
        // key to another without a release does not generate rollover.
        press_ev = commit && cand.single && !deb.single;
        drop     = press_ev && key_valid && !key_ack;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stab      <= 4'd0;
            last_cand <= CAND_NONE;
            deb       <= CAND_NONE;
        end else begin
            if (upd) begin
                stab <= stab_nxt;
                if (!same) begin
                    last_cand <= cand;
                end
            end
            if (commit) begin
                deb <= cand;
            end
        end
    end

    assign pressed = deb.single;

    // ------------------------------------------------------------------
    // One-entry key holder. An ack in the same cycle as a press frees the
    // slot, so the new key is taken rather than dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key       <= 4'h0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (press_ev) begin
                if (!key_valid || key_ack) begin
                    key       <= keymap(cand.pos);
                    key_valid <= 1'b1;
                end
            end else if (key_ack) begin
                key_valid <= 1'b0;
            end

            // A fresh drop beats a simultaneous clear.
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with N=2 (4-cycle slots, 16-cycle frames), D=2.
// A keypad model pulls row[r] low while key (r,c) is held and col[c] is low.
// cyc counts posedges since reset release, so cycle 16*f is the start of frame f.
module tb_keypad_scan;

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       key_ack;
    logic       pressed;
    logic       overrun;
    logic       overrun_clr;

    logic [15:0] keys;
    logic        force_zero;
    int          cyc;
    int          total;
    int          bad;

    keypad_scan #(
        .N (2),
        .D (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row         (row),
        .col         (col),
        .key         (key),
        .key_valid   (key_valid),
        .key_ack     (key_ack),
        .pressed     (pressed),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always_comb begin
        row = 4'hF;
        if (force_zero) begin
            row = 4'h0;
        end else begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
                end
            end
        end
    end

    task automatic goto(input int t);
        int guard;
        guard = 0;
        while (cyc < t && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < t) begin
            $display("FAIL goto_timeout cyc=%0d want=%0d", cyc, t);
            bad++;
            total++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; force_zero = 1'b1; keys = 16'h0;
        key_ack = 1'b0; overrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        if (col !== 4'b1110) begin $display("FAIL rst_col got=%b want=1110", col); bad++; end
        total++;
        if (key_valid !== 1'b0) begin $display("FAIL rst_key_valid got=%b want=0", key_valid); bad++; end
        total++;
        if (pressed !== 1'b0) begin $display("FAIL rst_pressed got=%b want=0", pressed); bad++; end
        total++;
        if (overrun !== 1'b0) begin $display("FAIL rst_overrun got=%b want=0", overrun); bad++; end
        total++;
        if (key !== 4'h0) begin $display("FAIL rst_key got=%h want=0", key); bad++; end
        total++;
        rst_n = 1'b1; force_zero = 1'b0;
        goto(3);
        if (col !== 4'b1110) begin $display("FAIL col_c3 got=%b want=1110", col); bad++; end
        total++;
        goto(4);
        if (col !== 4'b1101) begin $display("FAIL col_c4 got=%b want=1101", col); bad++; end
        total++;
        goto(8);
        if (col !== 4'b1011) begin $display("FAIL col_c8 got=%b want=1011", col); bad++; end
        total++;
        goto(12);
        if (col !== 4'b0111) begin $display("FAIL col_c12 got=%b want=0111", col); bad++; end
        total++;
        goto(16);
        if (col !== 4'b1110) begin $display("FAIL col_wrap got=%b want=1110", col); bad++; end
        total++;
    endtask

    task automatic test_single_press;
        goto(32); keys = 16'h0020;                 // "5" at r1,c1
        goto(64);
        if (key_valid !== 1'b0) begin $display("FAIL press5_early got=%b want=0", key_valid); bad++; end
        total++;
        goto(65);
        if (key_valid !== 1'b1) begin $display("FAIL press5_valid got=%b want=1", key_valid); bad++; end
        total++;
        if (key !== 4'h5) begin $display("FAIL press5_key got=%h want=5", key); bad++; end
        total++;
        if (pressed !== 1'b1) begin $display("FAIL press5_pressed got=%b want=1", pressed); bad++; end
        total++;
        goto(80); keys = 16'h0;
        goto(112);
        if (pressed !== 1'b1) begin $display("FAIL rel5_early got=%b want=1", pressed); bad++; end
        total++;
        goto(113);
        if (pressed !== 1'b0) begin $display("FAIL rel5_pressed got=%b want=0", pressed); bad++; end
        total++;
        if (key_valid !== 1'b1) begin $display("FAIL rel5_valid got=%b want=1", key_valid); bad++; end
        total++;
    endtask

    task automatic test_handshake;
        goto(120); key_ack = 1'b1;
        goto(121); key_ack = 1'b0;
        if (key_valid !== 1'b0) begin $display("FAIL ack5 got=%b want=0", key_valid); bad++; end
        total++;
        goto(128); keys = 16'h8000;                // "D" at r3,c3
        goto(161);
        if (key_valid !== 1'b1 || key !== 4'hD) begin
            $display("FAIL pressD got=%b/%h want=1/d", key_valid, key); bad++;
        end
        total++;
        goto(168); key_ack = 1'b1;
        goto(169); key_ack = 1'b0;
        if (key_valid !== 1'b0) begin $display("FAIL ackD got=%b want=0", key_valid); bad++; end
        total++;
        goto(224);
        if (key_valid !== 1'b0 || pressed !== 1'b1) begin
            $display("FAIL holdD got=%b/%b want=0/1", key_valid, pressed); bad++;
        end
        total++;
        keys = 16'h0;
        goto(257);
        if (pressed !== 1'b0 || key_valid !== 1'b0) begin
            $display("FAIL relD got=%b/%b want=0/0", pressed, key_valid); bad++;
        end
        total++;
    endtask

    task automatic test_overrun;
        keys = 16'h0001;                           // "1" at r0,c0 (cyc 256)
        goto(289);
        if (key_valid !== 1'b1 || key !== 4'h1) begin
            $display("FAIL press1 got=%b/%h want=1/1", key_valid, key); bad++;
        end
        total++;
        goto(304); keys = 16'h0;
        goto(336); keys = 16'h2000;                // "F" at r3,c1
        goto(369);
        if (key !== 4'h1) begin $display("FAIL ovr_key got=%h want=1", key); bad++; end
        total++;
        if (key_valid !== 1'b1) begin $display("FAIL ovr_valid got=%b want=1", key_valid); bad++; end
        total++;
        if (overrun !== 1'b1) begin $display("FAIL ovr_set got=%b want=1", overrun); bad++; end
        total++;
        if (pressed !== 1'b1) begin $display("FAIL ovr_pressed got=%b want=1", pressed); bad++; end
        total++;
        goto(376); overrun_clr = 1'b1;
        goto(377); overrun_clr = 1'b0;
        if (overrun !== 1'b0) begin $display("FAIL ovr_clr got=%b want=0", overrun); bad++; end
        total++;
        if (key_valid !== 1'b1 || key !== 4'h1) begin
            $display("FAIL ovr_clr_hold got=%b/%h want=1/1", key_valid, key); bad++;
        end
        total++;
        goto(384); keys = 16'h0;
        goto(416); keys = 16'h2000;
        goto(448); key_ack = 1'b1;                 // ack on the event cycle
        goto(449); key_ack = 1'b0;
        if (key !== 4'hF || key_valid !== 1'b1) begin
            $display("FAIL ackev got=%h/%b want=f/1", key, key_valid); bad++;
        end
        total++;
        if (overrun !== 1'b0) begin $display("FAIL ackev_ovr got=%b want=0", overrun); bad++; end
        total++;
        goto(456); key_ack = 1'b1;
        goto(457); key_ack = 1'b0;
        if (key_valid !== 1'b0) begin $display("FAIL ackF got=%b want=0", key_valid); bad++; end
        total++;
        goto(464); keys = 16'h0;
        goto(497);
        if (pressed !== 1'b0) begin $display("FAIL relF got=%b want=0", pressed); bad++; end
        total++;
    endtask

    task automatic test_bounce;
        for (int k = 0; k < 6; k++) begin
            goto(512 + 16*k);
            keys = (k % 2 == 0) ? 16'h0100 : 16'h0000;   // "7" at r2,c0
            goto(513 + 16*k);
            if (key_valid !== 1'b0 || pressed !== 1'b0) begin
                $display("FAIL bounce%0d got=%b/%b want=0/0", k, key_valid, pressed); bad++;
            end
            total++;
        end
        goto(625);
        if (key_valid !== 1'b0 || pressed !== 1'b0) begin
            $display("FAIL bounce_end got=%b/%b want=0/0", key_valid, pressed); bad++;
        end
        total++;
    endtask

    task automatic test_multi;
        goto(640); keys = 16'h0002;                // "2" at r0,c1
        goto(673);
        if (key_valid !== 1'b1 || key !== 4'h2) begin
            $display("FAIL press2 got=%b/%h want=1/2", key_valid, key); bad++;
        end
        total++;
        goto(680); key_ack = 1'b1;
        goto(681); key_ack = 1'b0;
        goto(688); keys = 16'h0402;                // add "9" at r2,c2
        goto(736); keys = 16'h0;
        goto(737);
        if (pressed !== 1'b1 || key_valid !== 1'b0) begin
            $display("FAIL multi_held got=%b/%b want=1/0", pressed, key_valid); bad++;
        end
        total++;
        goto(769);
        if (pressed !== 1'b0 || key_valid !== 1'b0) begin
            $display("FAIL multi_rel got=%b/%b want=0/0", pressed, key_valid); bad++;
        end
        total++;
        keys = 16'h0402;                           // both from idle
        goto(800); keys = 16'h0;
        goto(801);
        if (pressed !== 1'b0 || key_valid !== 1'b0) begin
            $display("FAIL multi_idle got=%b/%b want=0/0", pressed, key_valid); bad++;
        end
        total++;
    endtask

    task automatic test_reset_mid;
        goto(816); keys = 16'h0004;                // "3" at r0,c2
        goto(849);
        if (key_valid !== 1'b1 || key !== 4'h3) begin
            $display("FAIL press3 got=%b/%h want=1/3", key_valid, key); bad++;
        end
        total++;
        goto(864); keys = 16'h0;
        goto(881);
        keys  = 16'h0004;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        if (col !== 4'b1110 || key_valid !== 1'b0 || pressed !== 1'b0 || overrun !== 1'b0 || key !== 4'h0) begin
            $display("FAIL midrst got=%b/%b/%b/%b/%h want=1110/0/0/0/0",
                     col, key_valid, pressed, overrun, key); bad++;
        end
        total++;
        @(negedge clk);
        rst_n = 1'b1;
        goto(17);
        if (key_valid !== 1'b0 || pressed !== 1'b0) begin
            $display("FAIL midrst_frame1 got=%b/%b want=0/0", key_valid, pressed); bad++;
        end
        total++;
        goto(33);
        if (key_valid !== 1'b1 || key !== 4'h3) begin
            $display("FAIL midrst_frame2 got=%b/%h want=1/3", key_valid, key); bad++;
        end
        total++;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_single_press;
        test_handshake;
        test_overrun;
        test_bounce;
        test_multi;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
